// File: rtl/rc_pkg.sv
// Shared protocol bit positions and FSM state type for the remote-control
// motor command decoder.
package rc_pkg;

    localparam int HDR_BIT  = 7;
    localparam int STOP_BIT = 6;
    localparam int EN_BIT   = 6;
    localparam int DIR_BIT  = 5;
    localparam int MAG_W    = 5;
    localparam int CH_IDX_W = 3;

    typedef enum logic {
        IDLE,
        WAIT_DATA
    } rc_state_t;

endpackage

// File: rtl/rc_bump_sync.sv
// Two-flop synchroniser for the raw bumper switches, OR-reduced into a
// single bump_hit flag.
module rc_bump_sync #(
    parameter int BUMP_N = 6
) (
    input  logic              WF_CLK,
    input  logic              WF_BUTTON,
    input  logic [BUMP_N-1:0] bump,
    output logic              bump_hit
);

    logic [BUMP_N-1:0] sync_q1;
    logic [BUMP_N-1:0] sync_q2;

    always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
        if (!WF_BUTTON) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= bump;
            sync_q2 <= sync_q1;
        end
    end

    assign bump_hit = |sync_q2;

endmodule

// File: rtl/rc_motor_cmd.sv
// Two-byte frame decoder driving per-channel enable/direction/speed with a
// bumper interlock; define RC_WATCHDOG_EN to add the link-loss watchdog.
module rc_motor_cmd
    import rc_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int SPD_W       = 16,
    parameter int SPD_SHIFT   = 5,
    parameter int BUMP_N      = 6,
    parameter int WDOG_CYCLES = 12_000_000
) (
    input  logic                    WF_CLK,
    input  logic                    WF_BUTTON,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic [BUMP_N-1:0]       bump,
    output logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       ch_dir,
    output logic [NUM_CH*SPD_W-1:0] ch_spd,
    output logic                    bump_hit,
    output logic                    wdog_trip,
    output logic                    frame_err
);

    rc_state_t           state;
    logic [CH_IDX_W-1:0] cur_ch;
    logic                is_hdr;
    logic                is_stop;
    logic                ch_ok;
    logic                stop_all;
    logic                commit;
    logic                bad_byte;
    logic                fwd_blocked;
    logic                wdog_fire;
    logic [SPD_W-1:0]    new_spd;

    rc_bump_sync #(
        .BUMP_N(BUMP_N)
    ) u_bump_sync (
        .WF_CLK   (WF_CLK),
        .WF_BUTTON(WF_BUTTON),
        .bump     (bump),
        .bump_hit (bump_hit)
    );

    assign is_hdr      = rx_data[HDR_BIT];
    assign is_stop     = rx_data[STOP_BIT];
    assign ch_ok       = {1'b0, rx_data[CH_IDX_W-1:0]} < (CH_IDX_W+1)'(NUM_CH);
    assign stop_all    = rx_valid && is_hdr && is_stop;
    assign commit      = rx_valid && !is_hdr && (state == WAIT_DATA);
    assign fwd_blocked = bump_hit && !rx_data[DIR_BIT];
    assign new_spd     = SPD_W'(rx_data[MAG_W-1:0]) << SPD_SHIFT;
    assign bad_byte    = rx_valid && (is_hdr ? ((state == WAIT_DATA) || (!is_stop && !ch_ok))
                                             : (state == IDLE));

    // A commit owns its channel's enable for that cycle; every other channel
    // sees the stop-all, watchdog and forward-bumper clears.
    always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
        if (!WF_BUTTON) begin
            state     <= IDLE;
            cur_ch    <= '0;
            ch_en     <= '0;
            ch_dir    <= '0;
            ch_spd    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad_byte;
            if (rx_valid) begin
                if (is_hdr && !is_stop && ch_ok) begin
                    state  <= WAIT_DATA;
                    cur_ch <= rx_data[CH_IDX_W-1:0];
                end else begin
                    state <= IDLE;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit && (cur_ch == CH_IDX_W'(i))) begin
                    ch_en[i]                  <= rx_data[EN_BIT] && !fwd_blocked;
                    ch_dir[i]                 <= rx_data[DIR_BIT];
                    ch_spd[i*SPD_W +: SPD_W]  <= new_spd;
                end else if (stop_all || wdog_fire || (bump_hit && !ch_dir[i])) begin
                    ch_en[i] <= 1'b0;
                end
            end
        end
    end

`ifdef RC_WATCHDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] wdog_cnt;
    logic             wdog_held;

    assign wdog_fire = !wdog_held && (wdog_cnt == WDOG_LAST) && !commit && !stop_all;

    // After firing, the counter parks until link activity re-arms it.
    always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
        if (!WF_BUTTON) begin
            wdog_cnt  <= '0;
            wdog_held <= 1'b0;
            wdog_trip <= 1'b0;
        end else begin
            wdog_trip <= wdog_fire;
            if (commit || stop_all) begin
                wdog_cnt  <= '0;
                wdog_held <= 1'b0;
            end else if (wdog_fire) begin
                wdog_held <= 1'b1;
            end else if (!wdog_held) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_wdog;

    assign unused_wdog = (WDOG_CYCLES > 0);
    assign wdog_fire   = 1'b0;
    assign wdog_trip   = 1'b0;
`endif

endmodule

// File: tb/tb_rc_motor_cmd.sv
// Scoreboard bench for rc_motor_cmd: a byte-level protocol model queues the
// expected outputs for every byte driven and they are checked after the edge.
module tb_rc_motor_cmd;

    localparam int NUM_CH      = 2;
    localparam int SPD_W       = 16;
    localparam int SPD_SHIFT   = 5;
    localparam int BUMP_N      = 6;
    localparam int WDOG_CYCLES = 100;

    logic                    WF_CLK;
    logic                    WF_BUTTON;
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [BUMP_N-1:0]       bump;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_dir;
    logic [NUM_CH*SPD_W-1:0] ch_spd;
    logic                    bump_hit;
    logic                    wdog_trip;
    logic                    frame_err;

    typedef struct {
        string       tag;
        logic [1:0]  en;
        logic [1:0]  dir;
        logic [31:0] spd;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests;
    int          n_fail;
    logic [1:0]  m_en;
    logic [1:0]  m_dir;
    logic [15:0] m_spd [2];
    logic        m_wait;
    int          m_ch;
    logic        m_bump;
    int          trips;
    int          trip_at;
    int          r_ch;
    logic [7:0]  r_data;

    rc_motor_cmd #(
        .NUM_CH     (NUM_CH),
        .SPD_W      (SPD_W),
        .SPD_SHIFT  (SPD_SHIFT),
        .BUMP_N     (BUMP_N),
        .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .WF_CLK   (WF_CLK),
        .WF_BUTTON(WF_BUTTON),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .bump     (bump),
        .ch_en    (ch_en),
        .ch_dir   (ch_dir),
        .ch_spd   (ch_spd),
        .bump_hit (bump_hit),
        .wdog_trip(wdog_trip),
        .frame_err(frame_err)
    );

    initial WF_CLK = 1'b0;
    always #5 WF_CLK = ~WF_CLK;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic pushExpected(input string tag, input logic err);
        exp_t e;
        e.tag = tag;
        e.en  = m_en;
        e.dir = m_dir;
        e.spd = {m_spd[1], m_spd[0]};
        e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic popAndCompare();
        exp_t e;
        if (sb_q.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            checkOutput({e.tag, ".en"},  32'(ch_en),     32'(e.en));
            checkOutput({e.tag, ".dir"}, 32'(ch_dir),    32'(e.dir));
            checkOutput({e.tag, ".spd"}, 32'(ch_spd),    e.spd);
            checkOutput({e.tag, ".err"}, 32'(frame_err), 32'(e.err));
        end
    endtask

    // Reference protocol model, advanced once per received byte.
    task automatic modelByte(input string tag, input logic [7:0] b);
        logic err;
        err = 1'b0;
        if (b[7]) begin
            if (m_wait) err = 1'b1;
            if (b[6]) begin
                m_en   = 2'b00;
                m_wait = 1'b0;
            end else if (int'(b[2:0]) < NUM_CH) begin
                m_wait = 1'b1;
                m_ch   = int'(b[2:0]);
            end else begin
                err    = 1'b1;
                m_wait = 1'b0;
            end
        end else if (!m_wait) begin
            err = 1'b1;
        end else begin
            m_en[m_ch]  = b[6] && !(m_bump && !b[5]);
            m_dir[m_ch] = b[5];
            m_spd[m_ch] = 16'(b[4:0]) << SPD_SHIFT;
            m_wait      = 1'b0;
        end
        if (m_bump) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!m_dir[i]) m_en[i] = 1'b0;
            end
        end
        pushExpected(tag, err);
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] b);
        @(negedge WF_CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        modelByte(tag, b);
        @(posedge WF_CLK);
        #1;
        rx_valid = 1'b0;
        popAndCompare();
    endtask

    task automatic idleCheck(input string tag, input int n);
        repeat (n) @(posedge WF_CLK);
        #1;
        pushExpected(tag, 1'b0);
        popAndCompare();
    endtask

    task automatic resetModel();
        m_en     = 2'b00;
        m_dir    = 2'b00;
        m_spd[0] = 16'h0;
        m_spd[1] = 16'h0;
        m_wait   = 1'b0;
        m_ch     = 0;
        m_bump   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        WF_BUTTON = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        bump      = '0;
        resetModel();

        repeat (3) @(posedge WF_CLK);
        #1;
        checkOutput("rst_en",   32'(ch_en),     32'd0);
        checkOutput("rst_dir",  32'(ch_dir),    32'd0);
        checkOutput("rst_spd",  32'(ch_spd),    32'd0);
        checkOutput("rst_bump", 32'(bump_hit),  32'd0);
        checkOutput("rst_wdog", 32'(wdog_trip), 32'd0);
        checkOutput("rst_err",  32'(frame_err), 32'd0);
        @(negedge WF_CLK);
        WF_BUTTON = 1'b1;

        applyStimulus("ch1_hdr", 8'h81);
        applyStimulus("ch1_dat", 8'h5F);
        checkOutput("ch1_spd_abs", 32'(ch_spd[31:16]), 32'h03E0);

        applyStimulus("bad_ch", 8'h85);
        idleCheck("bad_ch_after", 1);
        applyStimulus("stray_dat", 8'h41);
        applyStimulus("chain_h0", 8'h80);
        applyStimulus("chain_h1", 8'h81);
        applyStimulus("chain_dat", 8'h41);
        idleCheck("chain_after", 1);

        applyStimulus("stop_all", 8'hC0);
        applyStimulus("wait_h", 8'h81);
        applyStimulus("wait_stop", 8'hC0);
        applyStimulus("wait_stray", 8'h41);

        applyStimulus("fwd0_h", 8'h80);
        applyStimulus("fwd0_d", 8'h4A);
        applyStimulus("rev1_h", 8'h81);
        applyStimulus("rev1_d", 8'h7F);
        @(negedge WF_CLK);
        bump = 6'b001000;
        @(posedge WF_CLK);
        #1;
        checkOutput("bump_e1_hit", 32'(bump_hit), 32'd0);
        @(posedge WF_CLK);
        #1;
        checkOutput("bump_e2_hit", 32'(bump_hit), 32'd1);
        checkOutput("bump_e2_en",  32'(ch_en),    32'd3);
        @(posedge WF_CLK);
        #1;
        checkOutput("bump_e3_en",  32'(ch_en),    32'd2);
        m_bump   = 1'b1;
        m_en[0]  = 1'b0;
        @(negedge WF_CLK);
        bump = '0;
        idleCheck("bump_release", 3);
        m_bump = 1'b0;
        checkOutput("bump_rel_hit", 32'(bump_hit), 32'd0);
        @(negedge WF_CLK);
        bump = 6'b000001;
        repeat (3) @(posedge WF_CLK);
        m_bump = 1'b1;
        #1;
        checkOutput("bump_rehold", 32'(bump_hit), 32'd1);
        applyStimulus("rev0_h", 8'h80);
        applyStimulus("rev0_d", 8'h6A);
        applyStimulus("fwd0b_h", 8'h80);
        applyStimulus("fwd0b_d", 8'h4A);
        @(negedge WF_CLK);
        bump = '0;
        repeat (3) @(posedge WF_CLK);
        m_bump = 1'b0;
        idleCheck("bump_final", 0);

        for (int k = 0; k < 16; k++) begin
            r_ch   = int'($urandom_range(0, NUM_CH - 1));
            r_data = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) applyStimulus("rnd_stray", r_data);
            applyStimulus("rnd_hdr", 8'h80 | 8'(r_ch));
            applyStimulus("rnd_dat", r_data);
        end

        applyStimulus("hold_h", 8'h81);
        applyStimulus("hold_d", 8'h7F);
        trips   = 0;
        trip_at = -1;
`ifdef RC_WATCHDOG_EN
        for (int k = 1; k <= 150; k++) begin
            @(posedge WF_CLK);
            #1;
            if (wdog_trip) begin
                trips++;
                if (trip_at < 0) trip_at = k;
            end
        end
        checkOutput("wdog_edge",  32'(trip_at), 32'd100);
        checkOutput("wdog_count", 32'(trips),   32'd1);
        m_en = 2'b00;
        idleCheck("wdog_en", 0);
`else
        for (int k = 1; k <= 1000; k++) begin
            @(posedge WF_CLK);
            #1;
            if (wdog_trip) trips++;
        end
        checkOutput("hold_trip", 32'(trips), 32'd0);
        idleCheck("hold_out", 0);
`endif

        applyStimulus("rst_mid_h", 8'h80);
        @(negedge WF_CLK);
        WF_BUTTON = 1'b0;
        #1;
        resetModel();
        checkOutput("rst_mid_en",  32'(ch_en),  32'd0);
        checkOutput("rst_mid_dir", 32'(ch_dir), 32'd0);
        checkOutput("rst_mid_spd", 32'(ch_spd), 32'd0);
        @(negedge WF_CLK);
        WF_BUTTON = 1'b1;
        applyStimulus("rst_mid_d", 8'h41);
        idleCheck("rst_mid_after", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
